hilo_ctrl: RTL and testbench

- Divide-issue and HI/LO result stage of the MIPS datapath; sits between execute and the iterative divider.
- Accepts DIV/DIVU/MTHI/MTLO from execute, launches the divider, waits on its done flag, and writes quotient to LO and remainder to HI.
- Serves MFHI/MFLO reads and raises a stall while a result is pending.

---
 rtl/hilo_pkg.sv | 26 ++
 rtl/hilo_ctrl.sv | 170 +++++++++++++++++
 tb/tb_hilo_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO divide-issue stage: op encodings, FSM states, default widths.
package hilo_pkg;

    localparam int W_DEF   = 32;
    localparam int TMO_DEF = 64;

    typedef enum logic [1:0] {
        OP_DIVU = 2'd0,
        OP_DIV  = 2'd1,
        OP_MTHI = 2'd2,
        OP_MTLO = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_WRITE  = 2'd3
    } state_e;

    // DIV and DIVU share op_code[1]=0; bit 0 selects signed mode.
    function automatic logic is_div(input op_e op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO result stage: issues divides to an external iterative divider, handles MTHI/MTLO/MFHI/MFLO.
// Optional divider watchdog enabled by defining HILO_WDOG_EN.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic         clk,
    input  logic         hilorst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [1:0]   op_code,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    input  logic         mf_req,
    input  logic         mf_sel,
    output logic [W-1:0] mf_data,
    output logic         stall,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    output logic         div_signed,
    output logic         div_start,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    input  logic         div_done,
    output logic         div_err
);

    state_e       state_reg, state_next;
    logic [W-1:0] hi_reg, hi_next;
    logic [W-1:0] lo_reg, lo_next;
    logic [W-1:0] div_a_reg, div_a_next;
    logic [W-1:0] div_b_reg, div_b_next;
    logic         div_signed_reg, div_signed_next;
    logic         first_reg, first_next;
    logic         rdy_reg;
    op_e          op;
    logic         accept;

`ifdef HILO_WDOG_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          err_reg, err_next;
`endif

    assign op = op_e'(op_code);

    // rdy_reg holds op_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge hilorst) begin
        if (hilorst) begin
            state_reg      <= S_IDLE;
            hi_reg         <= '0;
            lo_reg         <= '0;
            div_a_reg      <= '0;
            div_b_reg      <= '0;
            div_signed_reg <= 1'b0;
            first_reg      <= 1'b0;
            rdy_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hi_reg         <= hi_next;
            lo_reg         <= lo_next;
            div_a_reg      <= div_a_next;
            div_b_reg      <= div_b_next;
            div_signed_reg <= div_signed_next;
            first_reg      <= first_next;
            rdy_reg        <= 1'b1;
        end
    end

`ifdef HILO_WDOG_EN
    always_ff @(posedge clk or posedge hilorst) begin
        if (hilorst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end
`endif

    always_comb begin
        state_next      = state_reg;
        hi_next         = hi_reg;
        lo_next         = lo_reg;
        div_a_next      = div_a_reg;
        div_b_next      = div_b_reg;
        div_signed_next = div_signed_reg;
        first_next      = first_reg;
        div_start       = 1'b0;
        op_ready        = (state_reg == S_IDLE) && rdy_reg;
        accept          = op_valid && op_ready;
`ifdef HILO_WDOG_EN
        cnt_next        = cnt_reg;
        err_next        = err_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (is_div(op)) begin
                        if (rt_val == '0) begin
                            // Divide by zero resolves locally, without touching the divider.
                            hi_next = rs_val;
                            lo_next = '1;
                        end else begin
                            div_a_next      = rs_val;
                            div_b_next      = rt_val;
                            div_signed_next = op_code[0];
                            state_next      = S_LAUNCH;
                        end
                    end else if (op == OP_MTHI) begin
                        hi_next = rs_val;
                    end else begin
                        lo_next = rs_val;
                    end
                end
            end

            S_LAUNCH: begin
                div_start  = 1'b1;
                first_next = 1'b1;
                state_next = S_WAIT;
`ifdef HILO_WDOG_EN
                cnt_next   = '0;
`endif
            end

            S_WAIT: begin
                // div_done may still show the previous result on the first WAIT cycle.
                first_next = 1'b0;
                if (!first_reg && div_done) begin
                    state_next = S_WRITE;
`ifdef HILO_WDOG_EN
                end else if (cnt_reg == CW'(TMO - 1)) begin
                    hi_next    = '0;
                    lo_next    = '0;
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
`endif
                end
            end

            S_WRITE: begin
                lo_next    = div_q;
                hi_next    = div_r;
                state_next = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign stall      = (mf_req && (state_reg != S_IDLE)) || (op_valid && !op_ready);
    assign mf_data    = mf_sel ? hi_reg : lo_reg;
    assign div_a      = div_a_reg;
    assign div_b      = div_b_reg;
    assign div_signed = div_signed_reg;

`ifdef HILO_WDOG_EN
    assign div_err = err_reg;
`else
    assign div_err = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a 10-cycle behavioural divider model.
// Watchdog scenario runs only when HILO_WDOG_EN is defined.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         hilorst;
    logic         op_valid;
    logic         op_ready;
    logic [1:0]   op_code;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         mf_req;
    logic         mf_sel;
    logic [W-1:0] mf_data;
    logic         stall;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         div_signed;
    logic         div_start;
    logic [W-1:0] div_q = '0;
    logic [W-1:0] div_r = '0;
    logic         div_done = 1'b0;
    logic         div_err;

    int n_cmp = 0;
    int n_bad = 0;

    hilo_ctrl #(.W(W), .TMO(64)) dut (
        .clk(clk), .hilorst(hilorst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .rs_val(rs_val), .rt_val(rt_val),
        .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data), .stall(stall),
        .div_a(div_a), .div_b(div_b), .div_signed(div_signed), .div_start(div_start),
        .div_q(div_q), .div_r(div_r), .div_done(div_done), .div_err(div_err)
    );

    always #5 clk = ~clk;

    // Divider model: clears done one edge after the start pulse, result 10 edges later.
    int           starts = 0;
    int           mcnt = 0;
    logic         start_seen = 1'b0;
    logic         model_hang = 1'b0;
    logic [W-1:0] ma = '0, mb = '0;
    logic         ms = 1'b0;

    always @(posedge clk) begin
        start_seen <= div_start;
        if (div_start) begin
            starts <= starts + 1;
            ma     <= div_a;
            mb     <= div_b;
            ms     <= div_signed;
        end
        if (start_seen) begin
            div_done <= 1'b0;
            mcnt     <= model_hang ? 0 : 10;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                div_done <= 1'b1;
                if (ms) begin
                    div_q <= $unsigned($signed(ma) / $signed(mb));
                    div_r <= $unsigned($signed(ma) % $signed(mb));
                end else begin
                    div_q <= ma / mb;
                    div_r <= ma % mb;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hl(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        mf_sel = 1'b1;
        #1;
        check({tag, "_hi"}, mf_data, exp_hi);
        mf_sel = 1'b0;
        #1;
        check({tag, "_lo"}, mf_data, exp_lo);
    endtask

    task automatic wait_ready(input string tag, input int limit);
        for (int i = 0; i < limit && !op_ready; i++) @(negedge clk);
        check({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    endtask

    int stall_cycles;
    int starts0;

    initial begin
        hilorst  = 1'b1;
        op_valid = 1'b0;
        op_code  = 2'd0;
        rs_val   = '0;
        rt_val   = '0;
        mf_req   = 1'b0;
        mf_sel   = 1'b0;

        // Reset state
        #2;
        chk_hl("rst", 32'h0, 32'h0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_start", {31'd0, div_start}, 32'd0);
        check("rst_div_a", div_a, 32'h0);
        check("rst_err", {31'd0, div_err}, 32'd0);
        @(negedge clk);
        hilorst = 1'b0;
        #1;
        check("rst_ready_low", {31'd0, op_ready}, 32'd0);
        @(negedge clk);
        check("rst_ready_high", {31'd0, op_ready}, 32'd1);

        // DIVU 100/7 with MFLO held throughout
        op_valid = 1'b1; op_code = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        check("divu_start", {31'd0, div_start}, 32'd1);
        check("divu_a", div_a, 32'd100);
        check("divu_b", div_b, 32'd7);
        check("divu_signed", {31'd0, div_signed}, 32'd0);
        check("divu_ready", {31'd0, op_ready}, 32'd0);
        mf_req = 1'b1; mf_sel = 1'b0;
        #1;
        check("divu_stall", {31'd0, stall}, 32'd1);
        stall_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            stall_cycles++;
        end
        check("divu_stall_cycles", stall_cycles, 32'd13);
        check("divu_starts", starts, 32'd1);
        chk_hl("divu", 32'd2, 32'd14);
        mf_req = 1'b0;

        // DIV -7/2 signed; done is stale-high during the first WAIT cycle
        op_valid = 1'b1; op_code = OP_DIV; rs_val = 32'hFFFFFFF9; rt_val = 32'd2;
        @(negedge clk);
        op_valid = 1'b0;
        check("div_signed", {31'd0, div_signed}, 32'd1);
        wait_ready("div", 100);
        chk_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        check("div_starts", starts, 32'd2);

        // DIVU 5/0 completes in one cycle without the divider
        op_valid = 1'b1; op_code = OP_DIVU; rs_val = 32'd5; rt_val = 32'd0;
        #1;
        check("dz_ready_in", {31'd0, op_ready}, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
        check("dz_start", {31'd0, div_start}, 32'd0);
        check("dz_ready_out", {31'd0, op_ready}, 32'd1);
        chk_hl("dz", 32'd5, 32'hFFFFFFFF);
        @(negedge clk);
        check("dz_starts", starts, 32'd2);

        // MTHI then MFHI
        op_valid = 1'b1; op_code = OP_MTHI; rs_val = 32'hDEADBEEF;
        @(negedge clk);
        op_valid = 1'b0;
        mf_req = 1'b1; mf_sel = 1'b1;
        #1;
        check("mfhi_data", mf_data, 32'hDEADBEEF);
        check("mfhi_stall", {31'd0, stall}, 32'd0);
        mf_req = 1'b0;

        // MTLO offered while a DIVU 20/6 is in flight
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIVU; rs_val = 32'd20; rt_val = 32'd6;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MTLO; rs_val = 32'h00001234;
        #1;
        check("mt_wait_ready", {31'd0, op_ready}, 32'd0);
        check("mt_wait_stall", {31'd0, stall}, 32'd1);
        wait_ready("mt", 100);
        chk_hl("mt_pre", 32'd2, 32'd3);
        @(negedge clk);
        op_valid = 1'b0;
        chk_hl("mt_post", 32'd2, 32'h00001234);

        // Reset asserted during WAIT, then a fresh DIVU 9/3
        op_valid = 1'b1; op_code = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (4) @(negedge clk);
        mf_req = 1'b1;
        #1;
        check("mrst_stall_before", {31'd0, stall}, 32'd1);
        hilorst = 1'b1;
        #1;
        check("mrst_stall", {31'd0, stall}, 32'd0);
        chk_hl("mrst", 32'h0, 32'h0);
        hilorst = 1'b0;
        mf_req = 1'b0;
        @(negedge clk);
        check("mrst_ready", {31'd0, op_ready}, 32'd1);
        starts0 = starts;
        op_valid = 1'b1; op_code = OP_DIVU; rs_val = 32'd9; rt_val = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        check("mrst_start", {31'd0, div_start}, 32'd1);
        wait_ready("mrst_div", 100);
        chk_hl("mrst_div", 32'd0, 32'd3);
        check("mrst_starts", starts - starts0, 32'd1);

`ifdef HILO_WDOG_EN
        // Divider never finishes: watchdog must clear HI/LO and latch div_err
        op_valid = 1'b1; op_code = OP_MTHI; rs_val = 32'h55;
        @(negedge clk);
        op_valid = 1'b0;
        model_hang = 1'b1;
        op_valid = 1'b1; op_code = OP_DIVU; rs_val = 32'd10; rt_val = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("wd_err_early", {31'd0, div_err}, 32'd0);
        check("wd_ready_early", {31'd0, op_ready}, 32'd0);
        wait_ready("wd", 200);
        check("wd_err", {31'd0, div_err}, 32'd1);
        chk_hl("wd", 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("wd_err_sticky", {31'd0, div_err}, 32'd1);
`else
        check("no_wdog_err", {31'd0, div_err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
